// File: rtl/rv32im_ctrl_pkg.sv
// Shared types and constants for the RV32IM control path: opcodes, funct7
// values, operand/writeback selector enums, the ID/EX control bundle and M-sequencer states.
package rv32im_ctrl_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      SRC_A_REG  = 2'd0,
      SRC_A_PC   = 2'd1,
      SRC_A_ZERO = 2'd2
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRC_B_REG = 2'd0,
      SRC_B_IMM = 2'd1
   } alu_src_b_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_MD  = 2'd3
   } wb_sel_t;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       do_branch;
      logic       do_jump;
      alu_src_a_t alu_src_a;
      alu_src_b_t alu_src_b;
      wb_sel_t    wb_sel;
      logic [2:0] funct3;
      logic       is_md;
   } ctrl_bundle_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/rv32im_md_seq.sv
// Multi-cycle M-extension sequencer: holds the pipeline for LAT-1 cycles and
// pulses done on the last EX cycle of the operation.
module rv32im_md_seq
   import rv32im_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 33
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_flush,
   input  logic i_start,
   input  logic i_is_div,
   output logic o_stall_req,
   output logic o_md_done
);

   localparam logic [6:0] MUL_LAT = 7'(MUL_CYCLES);
   localparam logic [6:0] DIV_LAT = 7'(DIV_CYCLES);

   md_state_t  state_reg;
   logic [5:0] cnt_reg;
   logic [6:0] lat;
   logic       launch_long;
   logic       launch_short;

   assign lat          = i_is_div ? DIV_LAT : MUL_LAT;
   assign launch_long  = (state_reg == IDLE) && i_start && (lat > 7'd1);
   assign launch_short = (state_reg == IDLE) && i_start && (lat == 7'd1);

   // The first stalled cycle is spent in IDLE, so BUSY only has LAT-1 cycles left.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else if (i_flush) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (launch_long) begin
                  cnt_reg   <= 6'(lat - 7'd2);
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_reg != 6'd0) begin
                  cnt_reg <= cnt_reg - 6'd1;
               end else begin
                  state_reg <= IDLE;
               end
            end
         endcase
      end
   end

   assign o_stall_req = launch_long  || ((state_reg == BUSY) && (cnt_reg != 6'd0));
   assign o_md_done   = launch_short || ((state_reg == BUSY) && (cnt_reg == 6'd0));

endmodule

// File: rtl/rv32im_ctrl_pipe.sv
// RV32IM control path: full ID decode, ID/EX control register with stall/flush,
// and (when RV32M_EN is defined) the multi-cycle multiply/divide sequencer.
module rv32im_ctrl_pipe
   import rv32im_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 33
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_instr,
   input  logic        i_valid,
   input  logic        i_stall,
   input  logic        i_flush,
   output logic        o_illegal,
   output logic        o_ex_valid,
   output logic        o_ex_reg_write_en,
   output logic        o_ex_mem_write_en,
   output logic        o_ex_mem_read_en,
   output logic        o_ex_do_branch,
   output logic        o_ex_do_jump,
   output logic [1:0]  o_ex_alu_src_a,
   output logic [1:0]  o_ex_alu_src_b,
   output logic [1:0]  o_ex_wb_sel,
   output logic [2:0]  o_ex_funct3,
   output logic        o_ex_is_md,
   output logic        o_stall_req,
   output logic        o_md_done
);

   if (MUL_CYCLES < 1 || MUL_CYCLES > 64 || DIV_CYCLES < 1 || DIV_CYCLES > 64) begin : g_bad_param
      $fatal(1, "rv32im_ctrl_pipe: MUL_CYCLES and DIV_CYCLES must lie in 1..64");
   end

   logic [6:0]   opcode;
   logic [6:0]   funct7;
   logic         illegal_raw;
   ctrl_bundle_t dec;
   ctrl_bundle_t ex_next;
   ctrl_bundle_t ex_reg;
   logic         ex_load;
   logic         unused_instr_bits;

   assign opcode            = i_instr[6:0];
   assign funct7            = i_instr[31:25];
   assign unused_instr_bits = ^{i_instr[24:15], i_instr[11:7]};

   // Unrecognised encodings leave every enable at zero.
   always_comb begin
      dec         = '0;
      dec.funct3  = i_instr[14:12];
      illegal_raw = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE || funct7 == F7_ALT) begin
               dec.reg_write = 1'b1;
            end
`ifdef RV32M_EN
            else if (funct7 == F7_MULDIV) begin
               dec.reg_write = 1'b1;
               dec.is_md     = 1'b1;
               dec.wb_sel    = WB_MD;
            end
`endif
            else begin
               illegal_raw = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec.alu_src_b = SRC_B_IMM;
            dec.reg_write = 1'b1;
         end
         OPC_LOAD: begin
            dec.alu_src_b = SRC_B_IMM;
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
            dec.wb_sel    = WB_MEM;
         end
         OPC_STORE: begin
            dec.alu_src_b = SRC_B_IMM;
            dec.mem_write = 1'b1;
         end
         OPC_BRANCH: begin
            dec.alu_src_a = SRC_A_PC;
            dec.alu_src_b = SRC_B_IMM;
            dec.do_branch = 1'b1;
         end
         OPC_JAL: begin
            dec.alu_src_a = SRC_A_PC;
            dec.alu_src_b = SRC_B_IMM;
            dec.do_jump   = 1'b1;
            dec.reg_write = 1'b1;
            dec.wb_sel    = WB_PC4;
         end
         OPC_JALR: begin
            dec.alu_src_b = SRC_B_IMM;
            dec.do_jump   = 1'b1;
            dec.reg_write = 1'b1;
            dec.wb_sel    = WB_PC4;
         end
         OPC_LUI: begin
            dec.alu_src_a = SRC_A_ZERO;
            dec.alu_src_b = SRC_B_IMM;
            dec.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            dec.alu_src_a = SRC_A_PC;
            dec.alu_src_b = SRC_B_IMM;
            dec.reg_write = 1'b1;
         end
         default: illegal_raw = 1'b1;
      endcase
   end

   assign o_illegal = i_valid & illegal_raw;

   always_comb begin
      ex_next       = dec;
      ex_next.valid = i_valid & ~illegal_raw;
   end

   assign ex_load = ~o_stall_req & ~i_stall;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ex_reg <= '0;
      end else if (i_flush) begin
         ex_reg <= '0;
      end else if (ex_load) begin
         ex_reg <= ex_next;
      end
   end

   assign o_ex_valid        = ex_reg.valid;
   assign o_ex_reg_write_en = ex_reg.reg_write;
   assign o_ex_mem_write_en = ex_reg.mem_write;
   assign o_ex_mem_read_en  = ex_reg.mem_read;
   assign o_ex_do_branch    = ex_reg.do_branch;
   assign o_ex_do_jump      = ex_reg.do_jump;
   assign o_ex_alu_src_a    = ex_reg.alu_src_a;
   assign o_ex_alu_src_b    = ex_reg.alu_src_b;
   assign o_ex_wb_sel       = ex_reg.wb_sel;
   assign o_ex_funct3       = ex_reg.funct3;

`ifdef RV32M_EN
   logic fresh_reg;
   logic md_stall;
   logic md_done;

   // fresh marks the single cycle after a load, so a held M bundle never restarts.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fresh_reg <= 1'b0;
      end else if (i_flush) begin
         fresh_reg <= 1'b0;
      end else begin
         fresh_reg <= ex_load;
      end
   end

   rv32im_md_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md_seq (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (i_flush),
      .i_start     (ex_reg.valid & ex_reg.is_md & fresh_reg),
      .i_is_div    (ex_reg.funct3[2]),
      .o_stall_req (md_stall),
      .o_md_done   (md_done)
   );

   assign o_ex_is_md  = ex_reg.is_md;
   assign o_stall_req = md_stall;
   assign o_md_done   = md_done;
`else
   logic unused_md_bit;

   assign unused_md_bit = ex_reg.is_md;
   assign o_ex_is_md    = 1'b0;
   assign o_stall_req   = 1'b0;
   assign o_md_done     = 1'b0;
`endif

endmodule

// File: doc/rv32im_ctrl_pipe.md
# rv32im_ctrl_pipe

Second-generation control path for the RV32IM pipeline: decodes the full instruction word (opcode, funct3, funct7) in ID, registers the resulting control bundle into the ID/EX stage with stall/flush handling, and sequences multi-cycle M-extension operations in EX. It replaces the purely combinational opcode decoder. It sits between the IF/ID register and the execute stage. It is the sole source of the stall request raised by long-latency multiply/divide.

## Interface
Parameters:
- MUL_CYCLES, 1: EX occupancy of MUL/MULH/MULHSU/MULHU in cycles (1..64).
- DIV_CYCLES, 33: EX occupancy of DIV/DIVU/REM/REMU in cycles (1..64).

Ports:
- i_clk  in  1  clock. All state changes on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_instr  in  32  ID-stage instruction word.
- i_valid  in  1  i_instr holds a real instruction, not a bubble.
- i_stall  in  1  external hazard stall; holds the EX bundle.
- i_flush  in  1  squash: invalidates the EX bundle and aborts any M sequence.
- o_illegal  out  1  combinational flag: ID instruction is unrecognised (i_valid=1).
- o_ex_valid, o_ex_reg_write_en, o_ex_mem_write_en, o_ex_mem_read_en, o_ex_do_branch, o_ex_do_jump  out  1 each  registered control bits.
- o_ex_alu_src_a  out  2  REG=0, PC=1, ZERO=2.
- o_ex_alu_src_b  out  2  REG=0, IMM=1.
- o_ex_wb_sel  out  2  ALU=0, MEM=1, PC4=2, MD=3.
- o_ex_funct3  out  3  registered funct3; carries mem size, branch condition and M op.
- o_ex_is_md  out  1  EX bundle is an M-extension op.
- o_stall_req  out  1  request to hold IF/ID and ID/EX while the M op completes.
- o_md_done  out  1  one-cycle pulse: M result is valid this cycle.

## Operation
- Decode (combinational):
  - R-type: REG/REG, write, WB=ALU. With funct7=0000001: is_md=1, WB=MD.
  - I-ALU: REG/IMM, write.
  - LOAD: REG/IMM, read, write, WB=MEM.
  - STORE: REG/IMM, mem write.
  - BRANCH: PC/IMM, do_branch.
  - JAL: PC/IMM, jump, write, WB=PC4.
  - JALR: REG/IMM, jump, write, WB=PC4.
  - LUI: ZERO/IMM, write.
  - AUIPC: PC/IMM, write.
- Any other opcode, or an R-type funct7 outside {0000000, 0100000, 0000001}: o_illegal=1, and all enables decode to 0.
- EX register: on each edge where o_stall_req=0 and i_stall=0, it loads the decoded bundle, with valid = i_valid & ~o_illegal.
- i_flush has priority over everything: o_ex_valid←0, all enables ←0, FSM→IDLE.
- An internal bit `fresh` is set when the register loads and cleared on the next edge. A given M op starts its sequence only once, so a held bundle never retriggers.
- M sequencer: LAT = DIV_CYCLES if funct3[2] else MUL_CYCLES.
  - IDLE: if o_ex_valid & o_ex_is_md & fresh & LAT>1, then o_stall_req=1 this cycle, load cnt=LAT−2, go to BUSY. If LAT=1, o_md_done=1 the same cycle and stay in IDLE.
  - BUSY:
    - cnt≠0: o_stall_req=1, cnt decrements.
    - cnt=0: o_stall_req=0, o_md_done=1, go to IDLE.
- cnt is 6 bits and never underflows. Parameters outside 1..64 are a fatal elaboration error.

## Timing
- Reset: every o_ex_* output, o_stall_req and o_md_done are 0; FSM is IDLE; cnt=0; fresh=0.
- Decode-to-EX latency is 1 cycle.
- The M op occupies EX for exactly LAT cycles, with o_stall_req high for LAT−1 of them.
- o_md_done coincides with the last EX cycle of the op.
- o_stall_req is a Moore output of FSM, cnt and fresh only. It has no combinational path from i_instr.
- i_stall during BUSY: counting continues. If o_md_done fires while i_stall=1, the done pulse still occurs exactly once and the bundle stays held.
- i_flush together with o_md_done: the flush wins, and o_md_done is suppressed from the next cycle on.
- Reset asserted mid-BUSY: outputs clear immediately and asynchronously.

## Configuration
- RV32M_EN defined: M decode and the sequencer are compiled in, as described above.
- RV32M_EN undefined: funct7=0000001 decodes as illegal. o_ex_is_md, o_stall_req and o_md_done are tied to 0, and no FSM or counter is built.

## Structure
- Shared package `rv32im_ctrl_pkg` holds:
  - opcode constants;
  - the enums for alu_src_a, alu_src_b and wb_sel;
  - the funct7 constants;
  - the `ctrl_bundle_t` struct;
  - `md_state_t` {IDLE, BUSY}.
- Sub-module `rv32im_md_seq` (FSM plus counter). It is instantiated only under RV32M_EN.

## Test plan
- Reset is released, then ADD x1,x2,x3 (0x003100B3) with i_valid=1 → the next cycle shows ex_valid=1, reg_write=1, wb_sel=ALU, src=REG/REG.
- JALR x1,0(x5) → next cycle: src_a=REG, src_b=IMM, do_jump=1, wb_sel=PC4.
- DIV (funct7=1, funct3=100) with DIV_CYCLES=33 → o_stall_req high for 32 cycles, o_md_done on cycle 33, then the following instruction loads.
- MUL with MUL_CYCLES=1 → no stall, o_md_done pulses in the first EX cycle.
- i_flush on cycle 10 of a DIV → the next cycle has ex_valid=0, stall_req=0, and no o_md_done is ever issued.
- Opcode 0x7F with i_valid=1 → o_illegal=1 and the next cycle has ex_valid=0. Without RV32M_EN, MUL also raises o_illegal.
